// File: rtl/mem_bus_pkg.sv
// Shared types and default sizing for the memory bus initiator.
package mem_bus_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MIN_WAIT = 1;
  localparam int DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACC = 2'd1,
    WR_ACC = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Core request/response handshake plus memory strobes and address.
//
// Handshake: a request transfers on a rising edge where reqValid and
// reqReady are both 1; the core holds reqValid and its payload stable until
// then. rspValid is a one-cycle pulse with no back-pressure; rspErr and
// rspData are meaningful only while rspValid is 1. readyMem is a level held
// by memory and is only trusted once the strobe has been up MIN_WAIT cycles.
interface mem_bus_initiator_if #(
  parameter int ADDR_W = mem_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DEF_DATA_W
);
  logic              reqValid;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              reqReady;
  logic              rspValid;
  logic              rspErr;
  logic [DATA_W-1:0] rspData;
  logic              busy;
  logic              readMem;
  logic              writeMem;
  logic [ADDR_W-1:0] addrBus;
  logic              readyMem;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqWdata, readyMem,
    output reqReady, rspValid, rspErr, rspData, busy,
           readMem, writeMem, addrBus
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqWdata, readyMem,
    input  reqReady, rspValid, rspErr, rspData, busy,
           readMem, writeMem, addrBus
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Clear/enable cycle counter that flags the minimum strobe hold and timeout.
module mem_wait_timer #(
  parameter int MIN_WAIT = mem_bus_pkg::DEF_MIN_WAIT,
  parameter int TIMEOUT  = mem_bus_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  input  logic en,
  output logic minReached,
  output logic timedOut
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_WAIT);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count strobe cycles; saturate at TIMEOUT so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TO_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign minReached = (cnt_q >= MIN_C);
  assign timedOut   = (cnt_q >= TO_C);

endmodule

// File: rtl/mem_bus_initiator.sv
// Bus master turning single-word core requests into readMem/writeMem
// accesses with completion qualification, timeout and a one-cycle response.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MIN_WAIT = DEF_MIN_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rstN,
  mem_bus_initiator_if.master bus,
  inout  wire  [DATA_W-1:0]   dataBus,
  output state_e              dbgState,
  output logic                dbgDataOe
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic in_acc;
  logic min_reached;
  logic timed_out;
  logic done;
  logic data_oe;

  assign in_acc = (state_q == RD_ACC) || (state_q == WR_ACC);
  // A stale readyMem from the previous access is ignored until MIN_WAIT.
  assign done   = in_acc && min_reached && bus.readyMem;

  mem_wait_timer #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rstN       (rstN),
    .clr        (state_q == IDLE),
    .en         (in_acc),
    .minReached (min_reached),
    .timedOut   (timed_out)
  );

  // State register; async reset drops strobes and bus drive at once.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept in IDLE, leave an access on completion or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.reqValid) state_d = bus.reqWrite ? WR_ACC : RD_ACC;
      RD_ACC,
      WR_ACC:  if (done || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; dataBus is driven only during a write strobe.
  always_comb begin
    bus.reqReady  = (state_q == IDLE);
    bus.rspValid  = (state_q == RESP);
    bus.busy      = (state_q != IDLE);
    bus.readMem   = (state_q == RD_ACC);
    bus.writeMem  = (state_q == WR_ACC);
    data_oe       = (state_q == WR_ACC);
  end

  // Request capture and response data; completion beats timeout on a tie.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          addr_d  = bus.reqAddr;
          wdata_d = bus.reqWdata;
          err_d   = 1'b0;
        end
      end
      RD_ACC: begin
        if (done) begin
          rdata_d = dataBus;
          err_d   = 1'b0;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      WR_ACC: begin
        if (!done && timed_out) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; addrBus only moves on acceptance.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.addrBus = addr_q;
  assign bus.rspErr  = err_q;
  assign bus.rspData = rdata_q;
  assign dataBus     = data_oe ? wdata_q : {DATA_W{1'bz}};
  assign dbgState    = state_q;
  assign dbgDataOe   = data_oe;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench: DUT A uses MIN_WAIT=1/TIMEOUT=15, DUT B uses MIN_WAIT=3.
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus drive ----------------
  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        ready_lvl = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;

  mem_bus_initiator_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  mem_bus_initiator_if #(.ADDR_W(16), .DATA_W(16)) ifb ();
  wire [15:0] data_bus_a;
  wire [15:0] data_bus_b;
  state_e state_a, state_b;
  logic   oe_a, oe_b;

  assign ifa.reqValid = req_valid & ~sel;
  assign ifb.reqValid = req_valid & sel;
  assign ifa.reqWrite = req_write;
  assign ifb.reqWrite = req_write;
  assign ifa.reqAddr  = req_addr;
  assign ifb.reqAddr  = req_addr;
  assign ifa.reqWdata = req_wdata;
  assign ifb.reqWdata = req_wdata;
  assign ifa.readyMem = ready_lvl;
  assign ifb.readyMem = ready_lvl;

  mem_bus_initiator #(.ADDR_W(16), .DATA_W(16), .MIN_WAIT(1), .TIMEOUT(15)) dut_a (
    .clk(clk), .rstN(rstN), .bus(ifa), .dataBus(data_bus_a),
    .dbgState(state_a), .dbgDataOe(oe_a)
  );

  mem_bus_initiator #(.ADDR_W(16), .DATA_W(16), .MIN_WAIT(3), .TIMEOUT(15)) dut_b (
    .clk(clk), .rstN(rstN), .bus(ifb), .dataBus(data_bus_b),
    .dbgState(state_b), .dbgDataOe(oe_b)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:63];
  logic        mem_init_done = 1'b0;

  assign data_bus_a = ifa.readMem ? mem[ifa.addrBus[5:0]] : 16'hzzzz;
  assign data_bus_b = ifb.readMem ? mem[ifb.addrBus[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[0]        <= 16'hA5A5;
      mem[7]        <= 16'h7777;
      mem[30]       <= 16'h0005;
      mem_init_done <= 1'b1;
    end else if (ifa.writeMem) begin
      mem[ifa.addrBus[5:0]] <= data_bus_a;
    end else if (ifb.writeMem) begin
      mem[ifb.addrBus[5:0]] <= data_bus_b;
    end
  end

  // ---------------- observation mux ----------------
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy, o_read, o_write, o_oe;
  logic [15:0] o_rsp_data, o_addr, o_bus;
  state_e      o_state;

  always_comb begin
    o_req_ready = sel ? ifb.reqReady : ifa.reqReady;
    o_rsp_valid = sel ? ifb.rspValid : ifa.rspValid;
    o_rsp_err   = sel ? ifb.rspErr   : ifa.rspErr;
    o_rsp_data  = sel ? ifb.rspData  : ifa.rspData;
    o_busy      = sel ? ifb.busy     : ifa.busy;
    o_read      = sel ? ifb.readMem  : ifa.readMem;
    o_write     = sel ? ifb.writeMem : ifa.writeMem;
    o_addr      = sel ? ifb.addrBus  : ifa.addrBus;
    o_oe        = sel ? oe_b         : oe_a;
    o_bus       = sel ? data_bus_b   : data_bus_a;
    o_state     = sel ? state_b      : state_a;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [16:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: accept, follow strobes, capture the response, return to IDLE.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic rdy, output int lat, output logic err,
                           output logic [15:0] data, output int rd_n, output int wr_n,
                           output int bad);
    ready_lvl = rdy;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1; rd_n = 0; wr_n = 0; bad = 0; err = 1'b0; data = '0;
    while (!o_rsp_valid && lat < 40) begin
      if (o_read) begin
        rd_n++;
        if (o_oe || o_bus !== mem[a[5:0]]) bad++;
      end
      if (o_write) begin
        wr_n++;
        if (!o_oe || o_bus !== d) bad++;
      end
      if (o_req_ready || !o_busy) bad++;
      step();
      lat++;
    end
    if (o_rsp_valid) begin
      err  = o_rsp_err;
      data = o_rsp_data;
      if (o_read || o_write || o_oe || o_req_ready || !o_busy) bad++;
    end
    step();
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        rdy;
    logic        exp_err;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, rd_n, wr_n, bad, idx, prev, cnt;
    logic        err;
    logic [16:0] got, exp;
    logic [15:0] data;
    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_data [3];
    logic        b2b_w    [3];

    vecs[0] = '{1'b0, 16'd30,    16'h0000, 1'b1, 1'b0, 16'h0005, 3,  2,  0};
    vecs[1] = '{1'b1, 16'd40,    16'hBEEF, 1'b1, 1'b0, 16'h0005, 3,  0,  2};
    vecs[2] = '{1'b0, 16'd40,    16'h0000, 1'b1, 1'b0, 16'hBEEF, 3,  2,  0};
    vecs[3] = '{1'b0, 16'd7,     16'h0000, 1'b0, 1'b1, 16'h0000, 17, 16, 0};
    vecs[4] = '{1'b0, 16'd0,     16'h0000, 1'b1, 1'b0, 16'hA5A5, 3,  2,  0};
    vecs[5] = '{1'b1, 16'd12,    16'h1234, 1'b0, 1'b1, 16'hA5A5, 17, 0,  16};
    vecs[6] = '{1'b1, 16'd63,    16'hFFFF, 1'b1, 1'b0, 16'hA5A5, 3,  0,  2};
    vecs[7] = '{1'b0, 16'd63,    16'h0000, 1'b1, 1'b0, 16'hFFFF, 3,  2,  0};
    vecs[8] = '{1'b0, 16'hFFC0,  16'h0000, 1'b1, 1'b0, 16'hA5A5, 3,  2,  0};

    // ---- reset values, during and after reset ----
    #1;
    check("rst_state",    32'(o_state),     32'(IDLE));
    check("rst_write",    32'(o_write),     32'd0);
    repeat (3) @(posedge clk);
    #2 rstN = 1'b1;
    step();
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(o_rsp_err),   32'd0);
    check("rst_rsp_data",  32'(o_rsp_data),  32'd0);
    check("rst_busy",      32'(o_busy),      32'd0);
    check("rst_read",      32'(o_read),      32'd0);
    check("rst_addr",      32'(o_addr),      32'd0);
    check("rst_oe",        32'(o_oe),        32'd0);

    // ---- table-driven accesses on DUT A ----
    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rdy, lat, err, data, rd_n, wr_n, bad);
      check($sformatf("v%0d_err", i),  32'(err),    32'(vecs[i].exp_err));
      check($sformatf("v%0d_data", i), 32'(data),   32'(vecs[i].exp_data));
      check($sformatf("v%0d_lat", i),  32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rd", i),   32'(rd_n),   32'(vecs[i].exp_rd));
      check($sformatf("v%0d_wr", i),   32'(wr_n),   32'(vecs[i].exp_wr));
      check($sformatf("v%0d_bus", i),  32'(bad),    32'd0);
      check($sformatf("v%0d_addr", i), 32'(o_addr), 32'(vecs[i].a));
    end

    // ---- completion and timeout on the same edge: completion wins ----
    ready_lvl = 1'b0; req_write = 1'b0; req_addr = 16'd30; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (15) step();
    check("tie_no_early_rsp", 32'(o_rsp_valid), 32'd0);
    ready_lvl = 1'b1;
    step();
    check("tie_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("tie_rsp_err",   32'(o_rsp_err),   32'd0);
    check("tie_rsp_data",  32'(o_rsp_data),  32'h0005);
    step();

    // ---- back-to-back with reqValid held high ----
    b2b_w[0] = 1'b1; b2b_addr[0] = 16'd50; b2b_data[0] = 16'h1111;
    b2b_w[1] = 1'b0; b2b_addr[1] = 16'd50; b2b_data[1] = 16'h0000;
    b2b_w[2] = 1'b0; b2b_addr[2] = 16'd30; b2b_data[2] = 16'h0000;
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h1111});
    exp_q.push_back({1'b0, 16'h0005});
    idx = 0; prev = -1; bad = 0;
    ready_lvl = 1'b1;
    req_write = b2b_w[0]; req_addr = b2b_addr[0]; req_wdata = b2b_data[0];
    req_valid = 1'b1;
    for (int c = 0; c < 40 && (idx < 3 || exp_q.size() > 0); c++) begin
      logic acc;
      if (o_rsp_valid) begin
        got = {o_rsp_err, o_rsp_data};
        if (exp_q.size() == 0) begin
          check("b2b_extra_rsp", 32'(got), 32'h1FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("b2b_rsp", 32'(got), 32'(exp));
        end
      end
      if (o_busy && o_req_ready) bad++;
      acc = req_valid && o_req_ready;
      step();
      if (acc) begin
        if (prev >= 0) check("b2b_spacing", 32'(c - prev), 32'd4);
        prev = c;
        idx++;
        if (idx < 3) begin
          req_write = b2b_w[idx]; req_addr = b2b_addr[idx]; req_wdata = b2b_data[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts",   32'(idx),          32'd3);
    check("b2b_pending",   32'(exp_q.size()), 32'd0);
    check("b2b_ready_low", 32'(bad),          32'd0);
    step();

    // ---- stale readyMem on DUT B (MIN_WAIT=3) ----
    sel = 1'b1;
    step();
    do_access(1'b0, 16'd30, 16'h0000, 1'b1, lat, err, data, rd_n, wr_n, bad);
    check("stale1_lat",  32'(lat),  32'd5);
    check("stale1_rd",   32'(rd_n), 32'd4);
    check("stale1_data", 32'(data), 32'h0005);
    do_access(1'b0, 16'd40, 16'h0000, 1'b1, lat, err, data, rd_n, wr_n, bad);
    check("stale2_lat",  32'(lat),  32'd5);
    check("stale2_rd",   32'(rd_n), 32'd4);
    check("stale2_data", 32'(data), 32'hBEEF);
    check("stale2_err",  32'(err),  32'd0);
    check("stale2_bus",  32'(bad),  32'd0);
    sel = 1'b0;
    step();

    // ---- reset asserted mid-write ----
    ready_lvl = 1'b0; req_write = 1'b1; req_addr = 16'd20; req_wdata = 16'hABCD;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("mid_write_on", 32'(o_write), 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("mid_write_drop", 32'(o_write), 32'd0);
    check("mid_oe_drop",    32'(o_oe),    32'd0);
    check("mid_state",      32'(o_state), 32'(IDLE));
    cnt = 0;
    repeat (3) begin
      step();
      if (o_rsp_valid) cnt++;
    end
    #2 rstN = 1'b1;
    repeat (5) begin
      step();
      if (o_rsp_valid) cnt++;
    end
    check("mid_no_rsp",      32'(cnt),         32'd0);
    check("mid_state_after", 32'(o_state),     32'(IDLE));
    check("mid_req_ready",   32'(o_req_ready), 32'd1);
    check("mid_addr_reset",  32'(o_addr),      32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
